// File: rtl/isp_axis_pkg.sv
// rtl/isp_axis_pkg.sv - shared widths and helpers for ISP AXI-Stream width converters
//
// Contents:
//   PIX_W, PIX_PER_BEAT, BEAT_W, IDX_W  - pixel-stream geometry
//   keep_to_last_idx()                  - highest set keep bit, 0 when keep is empty
package isp_axis_pkg;

  localparam int PIX_W        = 24;
  localparam int PIX_PER_BEAT = 4;
  localparam int BEAT_W       = PIX_W * PIX_PER_BEAT;
  localparam int IDX_W        = 2;

  // Scanning upward leaves the highest set bit in the result.
  function automatic logic [IDX_W-1:0] keep_to_last_idx(input logic [PIX_PER_BEAT-1:0] keep);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < PIX_PER_BEAT; i++) begin
      if (keep[i]) r = i[IDX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_pix_sel.sv
// rtl/axis_pix_sel.sv - combinational N:1 pixel selector for width converters
//
// Ports:
//   data  in   PIX_W*N  packed pixels, pixel 0 in the low bits
//   idx   in   IDX_W    pixel to select
//   pix   out  PIX_W    selected pixel
module axis_pix_sel
  import isp_axis_pkg::*;
#(
  parameter int SEL_PIX_W = isp_axis_pkg::PIX_W,
  parameter int SEL_N     = isp_axis_pkg::PIX_PER_BEAT,
  parameter int SEL_IDX_W = isp_axis_pkg::IDX_W
) (
  input  logic [SEL_PIX_W*SEL_N-1:0] data,
  input  logic [SEL_IDX_W-1:0]       idx,
  output logic [SEL_PIX_W-1:0]       pix
);

  always_comb begin
    pix = '0;
    for (int i = 0; i < SEL_N; i++) begin
      if (idx == i[SEL_IDX_W-1:0]) pix = data[i*SEL_PIX_W +: SEL_PIX_W];
    end
  end

endmodule

// File: rtl/axis_pix96_serializer.sv
// rtl/axis_pix96_serializer.sv - 96-bit four-pixel AXI-Stream beat to 24-bit pixel stream
//
// Ports:
//   I_clk, I_rst                         clock, synchronous active-high reset
//   I_tdata/I_tkeep/I_tvalid/I_tready    input beat, four pixels, pixel 0 in [23:0]
//   I_tlast/I_tuser                      end of line / start of frame for the beat
//   O_tdata/O_tvalid/O_tready            one pixel per clock
//   O_tlast/O_tuser                      end of line / start of frame per pixel
module axis_pix96_serializer
  import isp_axis_pkg::*;
#(
  parameter int PIX_W        = isp_axis_pkg::PIX_W,
  parameter int PIX_PER_BEAT = isp_axis_pkg::PIX_PER_BEAT
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic [PIX_W*PIX_PER_BEAT-1:0] I_tdata,
  input  logic [PIX_PER_BEAT-1:0]       I_tkeep,
  input  logic                          I_tvalid,
  output logic                          I_tready,
  input  logic                          I_tlast,
  input  logic                          I_tuser,
  output logic [PIX_W-1:0]              O_tdata,
  output logic                          O_tvalid,
  input  logic                          O_tready,
  output logic                          O_tlast,
  output logic                          O_tuser
);

  logic [PIX_W*PIX_PER_BEAT-1:0] hold_data;
  logic [PIX_PER_BEAT-1:0]       hold_keep;
  logic                          hold_last;
  logic                          hold_user;
  logic                          hold_valid;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              last_idx;
  logic [PIX_PER_BEAT-1:0]       eff_keep;
  logic                          pix_fire;
  logic                          beat_done;
  logic                          in_fire;

  // Keep only matters on the line-end beat; an empty keep still carries one
  // pixel so that a beat is never silently dropped.
  always_comb begin
    eff_keep = I_tkeep;
    if (!I_tlast) begin
      eff_keep = '1;
    end else if (I_tkeep == '0) begin
      eff_keep = PIX_PER_BEAT'(1);
    end
  end

  assign last_idx  = keep_to_last_idx(hold_keep);
  assign pix_fire  = hold_valid & O_tready;
  assign beat_done = pix_fire & (idx == last_idx);
  // Accepting on beat_done lets the next beat follow the last pixel with no bubble.
  assign I_tready  = ~hold_valid | beat_done;
  assign in_fire   = I_tvalid & I_tready;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_last  <= 1'b0;
      hold_user  <= 1'b0;
      hold_valid <= 1'b0;
      idx        <= '0;
    end else if (in_fire) begin
      hold_data  <= I_tdata;
      hold_keep  <= eff_keep;
      hold_last  <= I_tlast;
      hold_user  <= I_tuser;
      hold_valid <= 1'b1;
      idx        <= '0;
    end else if (pix_fire) begin
      if (beat_done) begin
        hold_valid <= 1'b0;
        idx        <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  axis_pix_sel #(
    .SEL_PIX_W (PIX_W),
    .SEL_N     (PIX_PER_BEAT),
    .SEL_IDX_W (IDX_W)
  ) u_pix_sel (
    .data (hold_data),
    .idx  (idx),
    .pix  (O_tdata)
  );

  assign O_tvalid = hold_valid;
  assign O_tuser  = hold_user & (idx == '0);
  assign O_tlast  = hold_last & (idx == last_idx);

endmodule

// File: tb/tb_axis_pix96_serializer.sv
// tb/tb_axis_pix96_serializer.sv - directed self-checking bench for axis_pix96_serializer
module tb_axis_pix96_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tvalid;
  logic        i_tready;
  logic        i_tlast;
  logic        i_tuser;
  logic [23:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_tlast;
  logic        o_tuser;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
    logic        u;
  } px_t;

  always #5 clk = ~clk;

  axis_pix96_serializer dut (
    .I_clk    (clk),
    .I_rst    (rst),
    .I_tdata  (i_tdata),
    .I_tkeep  (i_tkeep),
    .I_tvalid (i_tvalid),
    .I_tready (i_tready),
    .I_tlast  (i_tlast),
    .I_tuser  (i_tuser),
    .O_tdata  (o_tdata),
    .O_tvalid (o_tvalid),
    .O_tready (o_tready),
    .O_tlast  (o_tlast),
    .O_tuser  (o_tuser)
  );

  // Inputs change 1 ns after the edge, outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mk_pix(input logic [7:0] tag, input int p);
    logic [7:0] pb;
    pb = 8'(p);
    return {tag, pb, tag ^ 8'hE7};
  endfunction

  function automatic logic [95:0] mk_beat(input logic [7:0] tag);
    logic [95:0] b;
    for (int p = 0; p < 4; p++) b[p*24 +: 24] = mk_pix(tag, p);
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", o_tvalid); end
    n_checks++; if (o_tdata !== 24'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 000000", o_tdata); end
    n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", o_tlast); end
    n_checks++; if (o_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b want 0", o_tuser); end
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b want 1", i_tready); end
  endtask

  task automatic test_single_beat();
    logic [23:0] exp_pix [4];
    exp_pix = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD};
    step();
    o_tready = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = 96'hDDDDDD_CCCCCC_BBBBBB_AAAAAA;
    i_tuser  = 1'b1;
    i_tlast  = 1'b0;
    i_tkeep  = 4'b0000;
    #1;
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b want 1", i_tready); end
    for (int p = 0; p < 4; p++) begin
      step();
      i_tvalid = 1'b0;
      i_tuser  = 1'b0;
      #1;
      n_checks++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_valid%0d: got %b want 1", p, o_tvalid); end
      n_checks++; if (o_tdata !== exp_pix[p]) begin n_fail++; $display("FAIL single_data%0d: got %h want %h", p, o_tdata, exp_pix[p]); end
      n_checks++; if (o_tuser !== (p == 0)) begin n_fail++; $display("FAIL single_user%0d: got %b want %b", p, o_tuser, (p == 0)); end
      n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL single_last%0d: got %b want 0", p, o_tlast); end
      n_checks++; if (i_tready !== (p == 3)) begin n_fail++; $display("FAIL single_ready%0d: got %b want %b", p, i_tready, (p == 3)); end
    end
    step();
    #1;
    n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", o_tvalid); end
  endtask

  task automatic test_continuous();
    int   sent;
    logic hs;
    logic [7:0] tag;
    o_tready = 1'b1;
    i_tuser  = 1'b0;
    i_tlast  = 1'b0;
    i_tkeep  = 4'b0010;
    step();
    i_tvalid = 1'b1;
    i_tdata  = mk_beat(8'h40);
    #1;
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL cont_ready0: got %b want 1", i_tready); end
    hs   = i_tvalid & i_tready;
    sent = 0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      step();
      if (hs) begin
        sent++;
        if (sent < 8) i_tdata = mk_beat(8'h40 + 8'(sent));
        else i_tvalid = 1'b0;
      end
      #1;
      if (cyc <= 32) begin
        tag = 8'h40 + 8'((cyc - 1) / 4);
        n_checks++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL cont_valid c%0d: got %b want 1", cyc, o_tvalid); end
        n_checks++; if (o_tdata !== mk_pix(tag, (cyc - 1) % 4)) begin n_fail++; $display("FAIL cont_data c%0d: got %h want %h", cyc, o_tdata, mk_pix(tag, (cyc - 1) % 4)); end
        n_checks++; if (i_tready !== ((cyc - 1) % 4 == 3)) begin n_fail++; $display("FAIL cont_ready c%0d: got %b want %b", cyc, i_tready, ((cyc - 1) % 4 == 3)); end
      end else begin
        n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got %b want 0", o_tvalid); end
      end
      hs = i_tvalid & i_tready;
    end
  endtask

  task automatic test_partial();
    logic [95:0] a;
    logic [95:0] b;
    a = mk_beat(8'h51);
    b = mk_beat(8'h62);
    o_tready = 1'b1;
    step();
    i_tvalid = 1'b1;
    i_tdata  = a;
    i_tlast  = 1'b1;
    i_tkeep  = 4'b0111;
    i_tuser  = 1'b0;
    #1;
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL part_ready_idle: got %b want 1", i_tready); end
    step();
    i_tdata = b;
    i_tkeep = 4'b0000;
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'h51, 0)) begin n_fail++; $display("FAIL part_p0: got %h want %h", o_tdata, mk_pix(8'h51, 0)); end
    n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL part_last0: got %b want 0", o_tlast); end
    n_checks++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL part_ready0: got %b want 0", i_tready); end
    step();
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'h51, 1)) begin n_fail++; $display("FAIL part_p1: got %h want %h", o_tdata, mk_pix(8'h51, 1)); end
    n_checks++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL part_last1: got %b want 0", o_tlast); end
    n_checks++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL part_ready1: got %b want 0", i_tready); end
    step();
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'h51, 2)) begin n_fail++; $display("FAIL part_p2: got %h want %h", o_tdata, mk_pix(8'h51, 2)); end
    n_checks++; if (o_tlast !== 1'b1) begin n_fail++; $display("FAIL part_last2: got %b want 1", o_tlast); end
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL part_ready2: got %b want 1", i_tready); end
    step();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    #1;
    n_checks++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL part_k0_valid: got %b want 1", o_tvalid); end
    n_checks++; if (o_tdata !== mk_pix(8'h62, 0)) begin n_fail++; $display("FAIL part_k0_data: got %h want %h", o_tdata, mk_pix(8'h62, 0)); end
    n_checks++; if (o_tlast !== 1'b1) begin n_fail++; $display("FAIL part_k0_last: got %b want 1", o_tlast); end
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL part_k0_ready: got %b want 1", i_tready); end
    step();
    #1;
    n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL part_drain: got %b want 0", o_tvalid); end
  endtask

  task automatic test_backpressure();
    px_t         q[$];
    px_t         front;
    int          sent;
    int          npix;
    int          cyc;
    logic        hs;
    logic        stall;
    logic [23:0] prev_d;
    logic        prev_l;
    logic        prev_u;
    logic [3:0]  keep_opts [4];
    keep_opts = '{4'b1111, 4'b0111, 4'b0011, 4'b0000};
    sent  = 0;
    hs    = 1'b0;
    stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    prev_u = 1'b0;
    i_tvalid = 1'b0;
    cyc = 0;
    while (cyc < 3000 && !(sent == 64 && q.size() == 0 && !o_tvalid)) begin
      step();
      if (hs) sent++;
      if (sent < 64) begin
        i_tvalid = 1'b1;
        i_tdata  = mk_beat(8'h80 + 8'(sent));
        i_tuser  = (sent % 8 == 0);
        i_tlast  = (sent % 8 == 7);
        i_tkeep  = i_tlast ? keep_opts[(sent / 8) % 4] : 4'b0100;
      end else begin
        i_tvalid = 1'b0;
      end
      o_tready = 1'($urandom_range(0, 1));
      #1;
      if (o_tvalid) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_extra: got pixel %h want none", o_tdata);
        end else begin
          front = q[0];
          n_checks++; if (o_tdata !== front.d) begin n_fail++; $display("FAIL bp_data c%0d: got %h want %h", cyc, o_tdata, front.d); end
          n_checks++; if (o_tlast !== front.l) begin n_fail++; $display("FAIL bp_last c%0d: got %b want %b", cyc, o_tlast, front.l); end
          n_checks++; if (o_tuser !== front.u) begin n_fail++; $display("FAIL bp_user c%0d: got %b want %b", cyc, o_tuser, front.u); end
        end
      end
      if (stall) begin
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== prev_d || o_tlast !== prev_l || o_tuser !== prev_u) begin
          n_fail++;
          $display("FAIL bp_stable c%0d: got v%b %h l%b u%b want v1 %h l%b u%b", cyc, o_tvalid, o_tdata, o_tlast, o_tuser, prev_d, prev_l, prev_u);
        end
      end
      if (o_tvalid && o_tready && q.size() > 0) void'(q.pop_front());
      hs = i_tvalid & i_tready;
      if (hs) begin
        case (i_tlast ? i_tkeep : 4'b1111)
          4'b1111: npix = 4;
          4'b0111: npix = 3;
          4'b0011: npix = 2;
          default: npix = 1;
        endcase
        for (int p = 0; p < npix; p++) begin
          q.push_back('{d: mk_pix(8'h80 + 8'(sent), p), l: (i_tlast && p == npix - 1), u: (i_tuser && p == 0)});
        end
      end
      stall  = o_tvalid & ~o_tready;
      prev_d = o_tdata;
      prev_l = o_tlast;
      prev_u = o_tuser;
      cyc++;
    end
    n_checks++; if (sent != 64) begin n_fail++; $display("FAIL bp_beats_sent: got %0d want 64", sent); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL bp_pixels_left: got %0d want 0", q.size()); end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tuser  = 1'b0;
  endtask

  task automatic test_reset_mid();
    o_tready = 1'b1;
    step();
    i_tvalid = 1'b1;
    i_tdata  = mk_beat(8'hA3);
    i_tuser  = 1'b0;
    i_tlast  = 1'b0;
    step();
    i_tvalid = 1'b0;
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'hA3, 0)) begin n_fail++; $display("FAIL rmid_p0: got %h want %h", o_tdata, mk_pix(8'hA3, 0)); end
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'hA3, 1)) begin n_fail++; $display("FAIL rmid_p1: got %h want %h", o_tdata, mk_pix(8'hA3, 1)); end
    step();
    rst      = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = mk_beat(8'hB4);
    i_tuser  = 1'b1;
    #1;
    n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", o_tvalid); end
    n_checks++; if (o_tdata !== 24'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 000000", o_tdata); end
    n_checks++; if (i_tready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", i_tready); end
    step();
    i_tvalid = 1'b0;
    i_tuser  = 1'b0;
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'hB4, 0)) begin n_fail++; $display("FAIL rmid_new_p0: got %h want %h", o_tdata, mk_pix(8'hB4, 0)); end
    n_checks++; if (o_tuser !== 1'b1) begin n_fail++; $display("FAIL rmid_new_user: got %b want 1", o_tuser); end
    step();
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'hB4, 1)) begin n_fail++; $display("FAIL rmid_new_p1: got %h want %h", o_tdata, mk_pix(8'hB4, 1)); end
    step();
    step();
    step();
    #1;
    n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain: got %b want 0", o_tvalid); end
  endtask

  task automatic test_sof_eol();
    o_tready = 1'b1;
    step();
    i_tvalid = 1'b1;
    i_tdata  = mk_beat(8'hC5);
    i_tuser  = 1'b1;
    i_tlast  = 1'b1;
    i_tkeep  = 4'b0001;
    step();
    i_tvalid = 1'b0;
    i_tuser  = 1'b0;
    i_tlast  = 1'b0;
    #1;
    n_checks++; if (o_tdata !== mk_pix(8'hC5, 0)) begin n_fail++; $display("FAIL sofeol_data: got %h want %h", o_tdata, mk_pix(8'hC5, 0)); end
    n_checks++; if (o_tuser !== 1'b1 || o_tlast !== 1'b1) begin n_fail++; $display("FAIL sofeol_flags: got u%b l%b want u1 l1", o_tuser, o_tlast); end
    step();
    #1;
    n_checks++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL sofeol_single: got %b want 0", o_tvalid); end
  endtask

  initial begin
    rst      = 1'b1;
    i_tdata  = '0;
    i_tkeep  = '0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tuser  = 1'b0;
    o_tready = 1'b0;
    test_reset();
    test_single_beat();
    test_continuous();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_sof_eol();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
